// File: rtl/ppa.sv
// ppa: 16-bit Brent-Kung parallel-prefix adder with carry-in/carry-out and a
// registered result.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset; clears the output registers
//             (and the input registers when they are present)
//   add_1  - addend A, unsigned 16 bits
//   add_2  - addend B, unsigned 16 bits
//   c_in   - carry-in at bit 0
//   sum    - registered (add_1 + add_2 + c_in) mod 2^16
//   c_out  - registered carry out of bit 15
//
// Build option:
//   PPA_IN_REG_EN - when defined, the operands pass through an input register
//                   stage before the prefix network (latency 2 instead of 1).
module ppa (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] add_1,
  input  logic [15:0] add_2,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_c;

`ifdef PPA_IN_REG_EN
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        cin_q, cin_d;

  always_comb begin
    a_d   = add_1;
    b_d   = add_2;
    cin_d = c_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      cin_q <= cin_d;
    end
  end

  assign op_a = a_q;
  assign op_b = b_q;
  assign op_c = cin_q;
`else
  assign op_a = add_1;
  assign op_b = add_2;
  assign op_c = c_in;
`endif

  logic [15:0] sum_q, sum_d;
  logic        c_out_q, c_out_d;

  // Prefix network. The group (G,P) vectors are updated in place level by
  // level; at every level each updated index reads only indices that the
  // same level leaves untouched, so in-place evaluation matches a
  // level-separated tree exactly.
  logic [15:0] bit_p;
  logic [15:0] grp_g;
  logic [15:0] grp_p;
  logic [15:0] carry;

  always_comb begin
    bit_p = op_a ^ op_b;
    grp_g = op_a & op_b;
    grp_p = bit_p;
    // Carry-in folded into bit 0 so it rides the prefix tree.
    grp_g[0] = grp_g[0] | (bit_p[0] & op_c);

    // Up-sweep: spans 2, 4, 8, 16 at indices ending in 2^k-1 patterns.
    for (int unsigned lvl = 0; lvl < 4; lvl++) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (((i + 1) % (2 << lvl)) == 0) begin
          grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - (1 << lvl)]);
          grp_p[i] = grp_p[i] & grp_p[i - (1 << lvl)];
        end
      end
    end

    // Down-sweep level 1: index 11 from 7.
    grp_g[11] = grp_g[11] | (grp_p[11] & grp_g[7]);
    grp_p[11] = grp_p[11] & grp_p[7];

    // Down-sweep level 2: indices 5, 9, 13 from 3, 7, 11.
    for (int unsigned i = 5; i < 15; i += 4) begin
      grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - 2]);
      grp_p[i] = grp_p[i] & grp_p[i - 2];
    end

    // Down-sweep level 3: even indices from their odd left neighbour.
    for (int unsigned i = 2; i < 16; i += 2) begin
      grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - 1]);
      grp_p[i] = grp_p[i] & grp_p[i - 1];
    end

    carry   = {grp_g[14:0], op_c};
    sum_d   = bit_p ^ carry;
    c_out_d = grp_g[15];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_ppa.sv
module tb_ppa;

  logic        clk;
  logic        rst;
  logic [15:0] add_1;
  logic [15:0] add_2;
  logic        c_in;
  logic [15:0] sum;
  logic        c_out;

  int checks;
  int errors;

  logic [16:0] exp_q[$];
  logic [16:0] pend;   // value held by the input stage (2-cycle build only)

  ppa dut (
    .clk   (clk),
    .rst   (rst),
    .add_1 (add_1),
    .add_2 (add_2),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact 17-bit unsigned sum.
  function automatic logic [16:0] ref_add(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic c);
    int unsigned s;
    s = int'(a) + int'(b) + int'(c);
    return s[16:0];
  endfunction

  // Applies one cycle of stimulus and queues the result expected after the
  // coming rising edge.
  task automatic drive(input logic r, input logic [15:0] a,
                       input logic [15:0] b, input logic c);
    logic [16:0] e;
    @(negedge clk);
    rst   = r;
    add_1 = a;
    add_2 = b;
    c_in  = c;
`ifdef PPA_IN_REG_EN
    e    = r ? 17'd0 : pend;
    pend = r ? 17'd0 : ref_add(a, b, c);
`else
    e = r ? 17'd0 : ref_add(a, b, c);
`endif
    exp_q.push_back(e);
  endtask

  // Monitor: result is presented every cycle.
  initial begin
    logic [16:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({c_out, sum} !== e) begin
          errors++;
          $display("FAIL sum_cout: got c_out=%0b sum=%0d, expected c_out=%0b sum=%0d",
                   c_out, sum, e[16], e[15:0]);
        end
      end
    end
  end

  initial begin
    logic [15:0] one_hot;
    checks = 0;
    errors = 0;
    pend   = '0;
    rst    = 1'b1;
    add_1  = 16'hABCD;
    add_2  = 16'h1234;
    c_in   = 1'b1;

    // Reset with arbitrary inputs.
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    drive(1'b1, 16'h1234, 16'h8765, 1'b0);

    // Directed values.
    drive(1'b0, 16'd4322,  16'd7656, 1'b1);
    drive(1'b0, 16'd987,   16'd71,   1'b0);
    drive(1'b0, 16'd65534, 16'd1,    1'b0);
    drive(1'b0, 16'd65534, 16'd1,    1'b1);
    drive(1'b0, 16'hFFFF,  16'h0000, 1'b1);
    drive(1'b0, 16'h0000,  16'h0000, 1'b0);

    // Back-to-back with reset in the middle.
    drive(1'b0, 16'd100,   16'd200,  1'b1);
    drive(1'b0, 16'd40000, 16'd30000, 1'b0);
    drive(1'b1, 16'd5555,  16'd6666, 1'b1);
    drive(1'b0, 16'd7,     16'd9,    1'b0);
    drive(1'b0, 16'hFFFF,  16'hFFFF, 1'b1);

    // Full-length propagate patterns.
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 16'hFFFF, 16'h0000, c[0]);
      drive(1'b0, 16'h0000, 16'hFFFF, c[0]);
      for (int k = 0; k < 16; k++) begin
        one_hot = 16'h0001 << k;
        drive(1'b0, one_hot, ~one_hot, c[0]);
        drive(1'b0, ~one_hot, one_hot, c[0]);
      end
    end

    // Random stimulus with occasional reset.
    for (int n = 0; n < 10000; n++) begin
      drive(($urandom_range(99) == 0), 16'($urandom), 16'($urandom),
            1'($urandom));
    end

    // Drain.
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
